// File: rtl/detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : detect_pkg
// Description : Shared state encoding and default widths for detect_arb.
// Revision    : 1.0 - initial release
// ============================================================================
package detect_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant with last-winner register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic r_last_id;

    // Under contention the requester that did not win last time is chosen.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last_id ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_id <= 1'b1;
        end else if (take && (req != 2'b00)) begin
            r_last_id <= gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/detect_arb.sv
`default_nettype none
// ============================================================================
// Module      : detect_arb
// Description : Arbitrates two word requesters onto one serial detector and
//               counts detector hits per word.
// Revision    : 1.0 - initial release
// ============================================================================
module detect_arb
    import detect_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [WORD_W-1:0] data0,
    input  logic [WORD_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              det_clr,
    output logic              det_in,
    input  logic              det_out,
    output logic              done,
    output logic              done_id,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              hit
);

    state_t             r_state;
    state_t             w_next;
    logic               r_owner;
    logic [WORD_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic               r_done_id;

    logic [1:0]         w_arb_gnt;
    logic               w_take;
    logic               w_last_bit;
    logic               w_sample;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_take     = (r_state == ST_IDLE) && (req0 || req1);
    assign w_last_bit = (r_idx == CNT_W'(WORD_W - 1));
    // det_out lags det_in by one cycle, so SHIFT cycle 0 carries no valid bit.
    assign w_sample   = ((r_state == ST_SHIFT) && (r_idx != '0)) || (r_state == ST_DRAIN);
    assign w_cnt_nxt  = (det_out && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({req1, req0}),
        .take (w_take),
        .gnt  (w_arb_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_take) w_next = ST_CLEAR;
            ST_CLEAR:  w_next = ST_SHIFT;
            ST_SHIFT:  if (w_last_bit) w_next = ST_DRAIN;
            ST_DRAIN:  w_next = ST_REPORT;
            ST_REPORT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt0    = (r_state == ST_CLEAR) && !r_owner;
        gnt1    = (r_state == ST_CLEAR) &&  r_owner;
        det_clr = (r_state == ST_CLEAR);
        det_in  = (r_state == ST_SHIFT) && r_shift[0];
        done    = (r_state == ST_REPORT);
        done_id = r_done_id;
        hit_cnt = r_hit_cnt;
        hit     = (r_hit_cnt != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= 1'b0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_hit_cnt <= '0;
            r_done_id <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_owner <= w_arb_gnt[1] & ~w_arb_gnt[0];
                        r_shift <= w_arb_gnt[1] ? data1 : data0;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
                ST_SHIFT: begin
                    r_shift <= r_shift >> 1;
                    r_idx   <= r_idx + CNT_W'(1);
                    if (w_sample) r_cnt <= w_cnt_nxt;
                end
                ST_DRAIN: begin
                    // Final sample goes straight into the reported result.
                    r_hit_cnt <= w_cnt_nxt;
                    r_done_id <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/detect_arb.md
DETECT_ARB -- requirements
Module: detect_arb

Interface
REQ-001 Parameter: WORD_W, default 8, serial word length in bits.
REQ-002 Parameter: CNT_W, default 4, hit counter width; SHALL satisfy 2^CNT_W > WORD_W.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low (rst=0 resets).
REQ-005 Port req0 / req1, input, 1 each: requester 0/1 has a word pending; held until granted.
REQ-006 Port data0 / data1, input, WORD_W each: word from requester 0/1; stable while its req is high.
REQ-007 Port gnt0 / gnt1, output, 1 each: one-cycle pulse; word captured from that requester.
REQ-008 Port det_clr, output, 1: one-cycle pulse returning the shared detector FSM to its start state.
REQ-009 Port det_in, output, 1: serial bit driven to the detector's in input.
REQ-010 Port det_out, input, 1: detector's out signal, Moore output, valid the cycle after each bit.
REQ-011 Port done, output, 1: one-cycle pulse; result fields valid.
REQ-012 Port done_id, output, 1: requester that owned the finished word.
REQ-013 Port hit_cnt, output, CNT_W: number of sampled det_out=1 bits for the finished word.
REQ-014 Port hit, output, 1: hit_cnt != 0, valid with done.

Function
REQ-015 FSM states: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
REQ-016 IDLE: if any req is high, grant per REQ-022, latch that data word into the shift register, and go to CLEAR. Otherwise stay in IDLE.
REQ-017 CLEAR, 1 cycle: det_clr=1, gntX=1 for the granted requester, hit counter=0, bit index=0. Next state is SHIFT.
REQ-018 SHIFT, WORD_W cycles: det_in = shift_reg[0], LSB first; shift right each cycle.
REQ-019 det_out SHALL be sampled in SHIFT cycles 1..WORD_W-1 and in DRAIN. det_out is not sampled in SHIFT cycle 0. This gives exactly WORD_W samples.
REQ-020 DRAIN, 1 cycle: det_in=0, final sample taken. Next state is REPORT.
REQ-021 REPORT, 1 cycle: done=1, done_id and hit_cnt/hit driven from registers. Next state is IDLE. Results hold until the next REPORT.
REQ-022 Arbitration is round-robin on last_id.
 - Only one req high: grant that requester.
 - Both req high: grant the requester != last_id.
 - last_id updates at grant.
REQ-023 req changes outside IDLE SHALL be ignored; no queuing; a req is never lost while held.
REQ-024 Latency: grant decision in cycle T, CLEAR T+1, SHIFT T+2..T+WORD_W+1, DRAIN T+WORD_W+2, done at T+WORD_W+3 (T+11 for WORD_W=8). The earliest next CLEAR is at T+WORD_W+5.
REQ-025 The hit counter saturates at 2^CNT_W-1; it never wraps.
REQ-026 det_in=0 in all states except SHIFT; det_clr=0 except in CLEAR; gnt0 and gnt1 are never high together.

Reset
REQ-027 On rst=0, the following SHALL take effect asynchronously:
 - state=IDLE
 - gnt0=gnt1=0, det_clr=0, det_in=0, done=0, done_id=0, hit_cnt=0, hit=0
 - shift register=0, bit index=0
 - last_id=1, so requester 0 wins the first contention.
REQ-028 Reset mid-word SHALL abandon the word with no done pulse. The requester SHALL re-request.
REQ-029 Release of rst is synchronous to clk. The first grant is possible on the first rising edge with rst=1.

Structure
REQ-030 Shared package detect_pkg SHALL hold the state enum, WORD_W and CNT_W defaults.
REQ-031 Sub-module rr_arb2 SHALL hold the 2-way round-robin grant logic and the last_id register. Its ports are clk, rst, req[1:0], take, gnt[1:0].
REQ-032 The bit index counter, shift register and hit counter live in detect_arb.

Verification
REQ-033 The bench SHALL model the detector as det_out = det_in delayed one clk.
REQ-034 Single request: req0=1, data0=0x5A.
 - gnt0 pulses at T+1.
 - det_in sequence is 0,1,0,1,1,0,1,0.
 - done at T+11 with done_id=0, hit_cnt=4, hit=1.
REQ-035 Contention after reset: req0=req1=1, data0=0x00, data1=0xFF.
 - Grant order is 0 then 1.
 - Results: hit_cnt=0 with hit=0, then hit_cnt=8 with hit=1.
 - det_clr pulses once per word.
REQ-036 Fairness: req1 and req0 held high for 4 words. Grants SHALL alternate 0,1,0,1, with no gap beyond one IDLE cycle between done and the next CLEAR.
REQ-037 Reset mid-word: rst=0 during SHIFT cycle 3. All outputs are 0 immediately, with no done pulse. After release, req0 with 0x01 yields hit_cnt=1.
REQ-038 Late request: req1 rises during SHIFT of word 0. It SHALL be ignored until IDLE, then granted. data1 changes after gnt1 SHALL NOT alter the result.
